// File: rtl/bdiv_pkg.sv
// Shared types and width constants for the sequential 2W/W restoring divider.
package bdiv_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} bdiv_state_t;
  localparam int BDIV_W = 32;
endpackage

// File: rtl/bdiv_step.sv
// One combinational restoring-division step: shift in one dividend bit, subtract B when it fits.
// No latency and no handshake of its own; the caller registers the results.
module bdiv_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_rem,
  output logic         o_q
);
  logic [W:0] w_t;

  assign w_t   = {i_rem, i_bit};
  assign o_q   = (w_t >= {1'b0, i_b});
  // A successful subtract always leaves a value below B, so W-bit modular arithmetic is exact.
  assign o_rem = o_q ? (w_t[W-1:0] - i_b) : w_t[W-1:0];
endmodule

// File: rtl/bdiv64x32_seq.sv
// Unsigned 2W/W restoring divider, one quotient bit per clock: result W cycles after accept (1 on ovf).
// in_ready only in IDLE; the result is held in DONE until out_ready, so a stalled sink blocks new ops.
module bdiv64x32_seq
  import bdiv_pkg::*;
#(
  parameter int W = BDIV_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] P,
  input  logic [W-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   R,
  output logic           ovf
);
  localparam int CNT_W = $clog2(W) + 1;

  bdiv_state_t    r_state;
  bdiv_state_t    w_state_nxt;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_r;
  logic           r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic [W-1:0]   w_rem_nxt;
  logic           w_qbit;
  logic           w_accept;
  logic           w_ovf_chk;
  logic           w_last;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Q         = r_q;
  assign R         = r_r;
  assign ovf       = r_ovf;

  assign w_accept  = in_valid && in_ready;
  // High half >= B means the quotient cannot fit in W bits; also catches B == 0.
  assign w_ovf_chk = (P[2*W-1:W] >= B);
  assign w_last    = (r_cnt == CNT_W'(W - 1));

  bdiv_step #(.W(W)) u_step (
    .i_rem (r_rem),
    .i_bit (r_quo[W-1]),
    .i_b   (r_b),
    .o_rem (w_rem_nxt),
    .o_q   (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_ovf_chk ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_b   <= B;
            r_rem <= P[2*W-1:W];
            r_quo <= P[W-1:0];
            r_cnt <= '0;
            if (w_ovf_chk) begin
              r_q   <= '1;
              r_r   <= '0;
              r_ovf <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[W-2:0], w_qbit};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_q   <= {r_quo[W-2:0], w_qbit};
            r_r   <= w_rem_nxt;
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
